// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: Funct codes, FSM states
// and the iteration counter width.
package mdu_pkg;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } mdu_state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bus between the EX stage and the multiply/divide unit.
interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [5:0]       Funct;
   logic [WIDTH-1:0] OpA;
   logic [WIDTH-1:0] OpB;
   logic             Flush;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ReadData;

   modport master (
      output Start, Funct, OpA, OpB, Flush,
      input  Busy, Done, ReadData
   );

   modport slave (
      input  Start, Funct, OpA, OpB, Flush,
      output Busy, Done, ReadData
   );
endinterface

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring shift-subtract for divide.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             div_mode_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
      shifted = {hi_i, lo_i[WIDTH-1]};
      diff    = shifted - {1'b0, m_i};
      hi_o    = hi_i;
      lo_o    = lo_i;
      if (div_mode_i) begin
         // A partial remainder with bit WIDTH set always exceeds the divisor,
         // so the restore path never needs that bit.
         if (!diff[WIDTH]) begin
            hi_o = diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_o = sum[WIDTH:1];
         lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with private HI/LO and MF*/MT* access.
// state | meaning
// IDLE  | accepts MT*/MULT*/DIV*; HI/LO readable
// MUL   | WIDTH shift-add steps on operand magnitudes
// DIV   | WIDTH restoring shift-subtract steps
// FIX   | apply result signs, write HI/LO, pulse Done
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter bit DIV0_LO = 1'b1
) (
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic             div0_q, div0_d;
   logic             is_div_q, is_div_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_hi, step_lo;
   logic             issue, sgn, a_neg, b_neg;
   logic [2*WIDTH-1:0] prod;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .div_mode_i (state_q == DIV),
      .hi_i       (acc_hi_q),
      .lo_i       (acc_lo_q),
      .m_i        (opb_q),
      .hi_o       (step_hi),
      .lo_o       (step_lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         div0_q   <= 1'b0;
         is_div_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         div0_q   <= div0_d;
         is_div_q <= is_div_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      div0_d   = div0_q;
      is_div_d = is_div_q;
      done_d   = 1'b0;
      prod     = {acc_hi_q, acc_lo_q};
      issue    = bus.Start && (state_q == IDLE) && !bus.Flush;
      sgn      = ~bus.Funct[0];
      a_neg    = sgn & bus.OpA[WIDTH-1];
      b_neg    = sgn & bus.OpB[WIDTH-1];

      unique case (state_q)
         IDLE: begin
            if (issue) begin
               case (bus.Funct)
                  FN_MTHI: hi_d = bus.OpA;
                  FN_MTLO: lo_d = bus.OpA;
                  FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                     acc_hi_d = '0;
                     acc_lo_d = a_neg ? -bus.OpA : bus.OpA;
                     opb_d    = b_neg ? -bus.OpB : bus.OpB;
                     neg_q_d  = a_neg ^ b_neg;
                     neg_r_d  = a_neg;
                     div0_d   = (bus.OpB == '0);
                     is_div_d = bus.Funct[1];
                     cnt_d    = '0;
                     state_d  = bus.Funct[1] ? DIV : MUL;
                  end
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
         FIX: begin
            if (is_div_q) begin
               // Remainder of a divide-by-zero is |OpA|, so sign-fixing restores OpA.
               hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
               if (div0_q)
                  lo_d = DIV0_LO ? '1 : '0;
               else
                  lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
            end else begin
               if (neg_q_q)
                  prod = -{acc_hi_q, acc_lo_q};
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over the completion edge: no write, no Done.
      if (bus.Flush && (state_q != IDLE)) begin
         state_d = IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   assign bus.Busy     = (state_q != IDLE);
   assign bus.Done     = done_q;
   assign bus.ReadData = bus.Funct[1] ? lo_q : hi_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for MULT/DIV results and latency,
// plus hand sequences for MT*/MF*, ignored Start, Flush and async reset.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   mdu_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32), .DIV0_LO(1'b1)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      bus.Funct = FN_MFHI;
      #1 h = bus.ReadData;
      bus.Funct = FN_MFLO;
      #1 l = bus.ReadData;
   endtask

   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      bus.Start = 1'b1;
      bus.Funct = f;
      bus.OpA   = v;
      tick();
      bus.Start = 1'b0;
   endtask

   // Issue one MULT*/DIV* and observe Busy/Done over a bounded window.
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output int done_n, output int done_at);
      bus.Start = 1'b1;
      bus.Funct = f;
      bus.OpA   = a;
      bus.OpB   = b;
      tick();
      bus.Start = 1'b0;
      busy_n = 0;
      done_n = 0;
      done_at = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.Busy) busy_n++;
         if (bus.Done) begin
            done_n++;
            done_at = k;
         end
         tick();
      end
   endtask

   initial begin
      logic [31:0] h, l, h0, l0;
      int busy_n, done_n, done_at;

      vecs[0]  = '{"mult_neg",     FN_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{"multu",        FN_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
      vecs[2]  = '{"divu_7_2",     FN_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      vecs[3]  = '{"div_m7_2",     FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{"div_ovf",      FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{"divu_by0",     FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
      vecs[6]  = '{"mult_maxpos",  FN_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[7]  = '{"div_7_m2",     FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8]  = '{"mult_minmin",  FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9]  = '{"div_neg_by0",  FN_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[10] = '{"multu_max",    FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

      bus.Start = 1'b0;
      bus.Funct = FN_MFHI;
      bus.OpA   = '0;
      bus.OpB   = '0;
      bus.Flush = 1'b0;
      repeat (3) tick();

      chk("reset_busy", {31'b0, bus.Busy}, 32'd0);
      chk("reset_done", {31'b0, bus.Done}, 32'd0);
      read_hilo(h, l);
      chk("reset_hi", h, 32'h0);
      chk("reset_lo", l, 32'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].funct, vecs[i].a, vecs[i].b, busy_n, done_n, done_at);
         read_hilo(h, l);
         chk({vecs[i].name, "_hi"}, h, vecs[i].exp_hi);
         chk({vecs[i].name, "_lo"}, l, vecs[i].exp_lo);
         chk({vecs[i].name, "_busy_cycles"}, busy_n, 32'd33);
         chk({vecs[i].name, "_done_count"}, done_n, 32'd1);
         chk({vecs[i].name, "_done_cycle"}, done_at, 32'd34);
      end

      // MTHI then MFHI next cycle; MT* never raises Busy or Done
      mt(FN_MTHI, 32'h00001234);
      chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
      chk("mthi_done", {31'b0, bus.Done}, 32'd0);
      bus.Funct = FN_MFHI;
      #1 chk("mfhi_after_mthi", bus.ReadData, 32'h00001234);
      mt(FN_MTLO, 32'h00005678);
      bus.Funct = FN_MFLO;
      #1 chk("mflo_after_mtlo", bus.ReadData, 32'h00005678);

      // Start with Flush high, or with a non-MDU Funct, does nothing
      bus.Flush = 1'b1;
      mt(FN_MTHI, 32'hCAFEF00D);
      bus.Flush = 1'b0;
      mt(6'h20, 32'h11111111);
      chk("bad_funct_busy", {31'b0, bus.Busy}, 32'd0);
      read_hilo(h, l);
      chk("flush_blocks_mthi", h, 32'h00001234);

      // Start(MTLO) while busy is ignored
      bus.Start = 1'b1;
      bus.Funct = FN_MULT;
      bus.OpA   = 32'hFFFFFFFE;
      bus.OpB   = 32'h00000003;
      tick();
      done_n = 0;
      for (int k = 1; k <= 40; k++) begin
         bus.Start = (k == 5);
         bus.Funct = (k == 5) ? FN_MTLO : FN_MFHI;
         bus.OpA   = (k == 5) ? 32'hDEADBEEF : 32'h0;
         if (bus.Done) done_n++;
         tick();
      end
      bus.Start = 1'b0;
      chk("busy_start_done", done_n, 32'd1);
      read_hilo(h, l);
      chk("busy_start_hi", h, 32'hFFFFFFFF);
      chk("busy_start_lo", l, 32'hFFFFFFFA);

      // Flush mid-DIV
      mt(FN_MTHI, 32'h0000AAAA);
      mt(FN_MTLO, 32'h0000BBBB);
      bus.Start = 1'b1;
      bus.Funct = FN_DIV;
      bus.OpA   = 32'h00000064;
      bus.OpB   = 32'h00000007;
      tick();
      bus.Start = 1'b0;
      done_n = 0;
      for (int k = 1; k <= 40; k++) begin
         bus.Flush = (k == 10);
         if (k == 10) chk("flush_busy_before", {31'b0, bus.Busy}, 32'd1);
         if (k == 11) chk("flush_busy_after", {31'b0, bus.Busy}, 32'd0);
         if (bus.Done) done_n++;
         tick();
      end
      bus.Flush = 1'b0;
      chk("flush_no_done", done_n, 32'd0);
      read_hilo(h, l);
      chk("flush_hi_kept", h, 32'h0000AAAA);
      chk("flush_lo_kept", l, 32'h0000BBBB);

      // Flush coinciding with the completion edge suppresses the write
      read_hilo(h0, l0);
      bus.Start = 1'b1;
      bus.Funct = FN_MULTU;
      bus.OpA   = 32'h00000005;
      bus.OpB   = 32'h00000006;
      tick();
      bus.Start = 1'b0;
      repeat (32) tick();
      chk("fix_busy", {31'b0, bus.Busy}, 32'd1);
      bus.Flush = 1'b1;
      tick();
      bus.Flush = 1'b0;
      chk("fix_flush_busy", {31'b0, bus.Busy}, 32'd0);
      chk("fix_flush_done", {31'b0, bus.Done}, 32'd0);
      read_hilo(h, l);
      chk("fix_flush_hi", h, h0);
      chk("fix_flush_lo", l, l0);

      // Async reset mid-DIV
      bus.Start = 1'b1;
      bus.Funct = FN_DIV;
      bus.OpA   = 32'h00000064;
      bus.OpB   = 32'h00000007;
      tick();
      bus.Start = 1'b0;
      repeat (9) tick();
      chk("rst_busy_before", {31'b0, bus.Busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_busy_now", {31'b0, bus.Busy}, 32'd0);
      read_hilo(h, l);
      chk("rst_hi", h, 32'h0);
      chk("rst_lo", l, 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (40) tick();
      chk("rst_no_done", {31'b0, bus.Done}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
